// File: rtl/nn_frame_feeder.sv
// nn_frame_feeder: collects a byte-serial 28x28 frame into the parallel image
// array, then pulses the network reset, runs it until done or timeout, and
// returns the recognised digit on a valid/ready result handshake.
module nn_frame_feeder #(
  parameter int NUM_PIXELS     = 784,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pixel_data,
  input  logic        pixel_sof,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [7:0]  imagine [0:NUM_PIXELS-1],
  output logic        nn_reset,
  output logic        nn_enable,
  input  logic [7:0]  nn_digit,
  input  logic        nn_done,
  output logic [7:0]  result_digit,
  output logic        result_timeout,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic [15:0] frames_done
);

  localparam int IDX_W   = $clog2(NUM_PIXELS + 1);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_img [0:NUM_PIXELS-1];
  logic             r_nn_reset, r_nn_enable;
  logic [7:0]       r_res_digit;
  logic             r_res_timeout, r_res_valid;
  logic [15:0]      r_frames;

  logic             w_xfer, w_frame_end, w_clear_end, w_run_done, w_run_to, w_res_take;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;

  assign w_xfer      = pixel_valid & pixel_ready;
  // The last pixel only ends the frame if it is not itself a restart.
  assign w_frame_end = (r_state == S_LOAD) & w_xfer & ~pixel_sof & (r_idx == LAST_IDX);
  assign w_clear_end = (r_state == S_CLEAR) & (r_cnt == RST_LAST);
  // nn_done has priority over the timeout when both land on the same cycle.
  assign w_run_done  = (r_state == S_RUN) & nn_done;
  assign w_run_to    = (r_state == S_RUN) & ~nn_done & (r_cnt == TO_LAST);
  assign w_res_take  = (r_state == S_DONE) & r_res_valid & result_ready;
  // Non-sof pixels seen in IDLE are accepted but dropped.
  assign w_wr_en     = w_xfer & (pixel_sof | (r_state == S_LOAD));
  assign w_wr_addr   = pixel_sof ? '0 : r_idx;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && pixel_sof)        w_next = S_LOAD;
      S_LOAD:  if (w_frame_end)                w_next = S_CLEAR;
      S_CLEAR: if (w_clear_end)                w_next = S_RUN;
      S_RUN:   if (w_run_done || w_run_to)     w_next = S_DONE;
      S_DONE:  if (w_res_take)                 w_next = S_IDLE;
      default:                                 w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; pixel_ready deliberately ignores pixel_valid.
  always_comb begin
    pixel_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
    busy        = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DONE);
  end

  // Pixel index: sof always restarts at 1, wraps to 0 when the frame completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      if (pixel_sof)               r_idx <= IDX_W'(1);
      else if (r_state == S_LOAD)  r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
    end
  end

  // Image array: written only while loading, so it is frozen while the network runs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) r_img[i] <= '0;
    end else if (w_wr_en) begin
      r_img[w_wr_addr] <= pixel_data;
    end
  end

  assign imagine = r_img;

  // Shared cycle counter: reset-hold length in CLEAR, run length in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   r_cnt <= '0;
    else if (w_frame_end)         r_cnt <= '0;
    else if (r_state == S_CLEAR)  r_cnt <= w_clear_end ? '0 : r_cnt + 1'b1;
    else if (r_state == S_RUN)    r_cnt <= r_cnt + 1'b1;
  end

  // Network control: reset held from frame end until CLEAR exit, enable only in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_nn_reset  <= 1'b1;
      r_nn_enable <= 1'b0;
    end else begin
      if (w_frame_end) r_nn_reset <= 1'b1;
      if (w_clear_end) begin
        r_nn_reset  <= 1'b0;
        r_nn_enable <= 1'b1;
      end
      if (w_run_done || w_run_to) r_nn_enable <= 1'b0;
    end
  end

  // Result capture and hand-off; result holds until consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_res_digit   <= '0;
      r_res_timeout <= 1'b0;
      r_res_valid   <= 1'b0;
      r_frames      <= '0;
    end else begin
      if (w_run_done) begin
        r_res_digit   <= nn_digit;
        r_res_timeout <= 1'b0;
        r_res_valid   <= 1'b1;
      end else if (w_run_to) begin
        r_res_digit   <= 8'hFF;
        r_res_timeout <= 1'b1;
        r_res_valid   <= 1'b1;
      end
      if (w_res_take) begin
        r_res_valid <= 1'b0;
        r_frames    <= r_frames + 16'd1;
      end
    end
  end

  assign nn_reset       = r_nn_reset;
  assign nn_enable      = r_nn_enable;
  assign result_digit   = r_res_digit;
  assign result_timeout = r_res_timeout;
  assign result_valid   = r_res_valid;
  assign frames_done    = r_frames;

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Bench for nn_frame_feeder: random pixel streams and network delays checked
// against a frame/result model built from the block's rules.
module tb_nn_frame_feeder;
  localparam int N  = 784;
  localparam int RC = 2;
  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pixel_data = '0;
  logic        pixel_sof = 1'b0, pixel_valid = 1'b0, pixel_ready;
  logic [7:0]  img [0:N-1];
  logic        nn_reset, nn_enable;
  logic [7:0]  nn_digit = '0;
  logic        nn_done = 1'b0;
  logic [7:0]  result_digit;
  logic        result_timeout, result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic [15:0] frames_done;

  always #5 clock = ~clock;

  nn_frame_feeder #(.NUM_PIXELS(N), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .pixel_data(pixel_data), .pixel_sof(pixel_sof), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .imagine(img),
    .nn_reset(nn_reset), .nn_enable(nn_enable), .nn_digit(nn_digit), .nn_done(nn_done),
    .result_digit(result_digit), .result_timeout(result_timeout),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .frames_done(frames_done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_img [0:N-1];
  int         m_idx;
  bit         m_loading;
  int         m_frames;
  logic [7:0] m_dig;
  logic       m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic img_check(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (img[i] !== m_img[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // One pixel transfer with an occasional idle gap; model applies frame rules.
  task automatic push(input logic [7:0] d, input logic s);
    int w = 0;
    if ($urandom_range(0, 3) == 0) begin pixel_valid = 1'b0; tick(); end
    pixel_data = d; pixel_sof = s; pixel_valid = 1'b1;
    while (pixel_ready !== 1'b1 && w < 50) begin tick(); w++; end
    if (pixel_ready !== 1'b1) begin
      chk("ready_wait", pixel_ready, 1);
      pixel_valid = 1'b0;
      return;
    end
    tick();
    pixel_valid = 1'b0;
    if (s) begin
      m_img[0] = d; m_idx = 1; m_loading = 1;
    end else if (m_loading) begin
      m_img[m_idx] = d; m_idx++;
      if (m_idx == N) begin m_loading = 0; m_idx = 0; end
    end
  endtask

  // mode 0: i mod 256, 1: random, 2: constant 8'h55. Checks the reset pulse after the last accept.
  task automatic send_frame(input int mode);
    logic [7:0] v;
    for (int i = 0; i < N; i++) begin
      v = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom) : 8'h55;
      push(v, i == 0);
    end
    chk("clr_ready", pixel_ready, 0);
    chk("clr_busy", busy, 1);
    chk("clr_rst", nn_reset, 1);
    chk("clr_en", nn_enable, 0);
    chk("clr_rv", result_valid, 0);
    for (int c = 1; c < RC; c++) begin
      tick();
      chk("clr_rst_hold", nn_reset, 1);
      chk("clr_en_hold", nn_enable, 0);
    end
    tick();
    chk("run_rst", nn_reset, 0);
    chk("run_en", nn_enable, 1);
    chk("run_ready", pixel_ready, 0);
    img_check("img");
  endtask

  // Network raises nn_done on RUN cycle d (1-based); beyond TO the run times out.
  task automatic run_net(input int d, input logic [7:0] dig);
    int e = (d < TO) ? d : TO;
    m_to  = (d > TO);
    m_dig = m_to ? 8'hFF : dig;
    nn_digit = dig;
    for (int j = 1; j <= e; j++) begin
      if (j >= d) nn_done = 1'b1;
      chk("run_en_hi", nn_enable, 1);
      chk("run_rv_lo", result_valid, 0);
      tick();
    end
    nn_done = 1'b0;
    chk("res_valid", result_valid, 1);
    chk("res_digit", result_digit, m_dig);
    chk("res_timeout", result_timeout, m_to);
    chk("res_en", nn_enable, 0);
    chk("res_busy", busy, 1);
    chk("res_ready", pixel_ready, 0);
  endtask

  task automatic take_result(input int hold);
    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      pixel_valid = 1'b1; pixel_data = 8'($urandom); pixel_sof = 1'($urandom);
      tick();
      chk("hold_valid", result_valid, 1);
      chk("hold_digit", result_digit, m_dig);
      chk("hold_timeout", result_timeout, m_to);
      chk("hold_ready", pixel_ready, 0);
    end
    pixel_valid = 1'b0; pixel_sof = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    m_frames++;
    chk("take_rv", result_valid, 0);
    chk("take_frames", frames_done, m_frames);
    chk("take_busy", busy, 0);
    chk("take_ready", pixel_ready, 1);
    if (hold > 0) img_check("img_hold");
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0;
    reset = 1'b0;
    #2;
    for (int i = 0; i < N; i++) m_img[i] = '0;
    m_idx = 0; m_loading = 0; m_frames = 0;
    chk("rst_nn_reset", nn_reset, 1);
    chk("rst_nn_enable", nn_enable, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_digit", result_digit, 0);
    chk("rst_timeout", result_timeout, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pixel_ready, 1);
    img_check("rst_img");
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // Incrementing frame, fast network answer of 7.
    send_frame(0);
    result_ready = 1'b1;
    run_net($urandom_range(2, 60), 8'd7);
    take_result(0);

    // Partial frame abandoned by a fresh sof, then a constant frame.
    for (int i = 0; i < 300; i++) push(8'($urandom), i == 0);
    chk("partial_busy", busy, 0);
    chk("partial_ready", pixel_ready, 1);
    send_frame(2);
    run_net($urandom_range(1, 63), 8'($urandom));
    take_result(0);

    // Timeout, then done landing exactly on the last allowed cycle with a held result.
    send_frame(1);
    run_net(1000, 8'h12);
    take_result(0);
    send_frame(1);
    run_net(TO, 8'd3);
    take_result(20);

    // Stray non-sof pixels in IDLE and a stale nn_done level during load.
    for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0);
    nn_done = 1'b1;
    send_frame(1);
    run_net(1, 8'h09);
    take_result(0);

    // Reset in the middle of a frame load.
    for (int i = 0; i < 400; i++) push(8'($urandom), i == 0);
    do_reset();
    for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0);
    chk("discard_busy", busy, 0);
    img_check("discard_img");

    // Reset in the middle of a run.
    send_frame(1);
    for (int i = 0; i < 10; i++) tick();
    chk("midrun_en", nn_enable, 1);
    do_reset();

    // Recovery: one complete frame after the aborted run.
    send_frame(1);
    run_net($urandom_range(1, 50), 8'($urandom));
    take_result($urandom_range(0, 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
